// File: rtl/bayer_bin_demosaic.sv
// bayer_bin_demosaic: bins each 2x2 BGGR quad of the OV7670 raw stream into
// one RGB444 pixel with its quarter-resolution video-buffer write address.
// Even rows park {B,G1} in a half-width line buffer; odd rows combine it
// with {G2,R} and emit one pixel per quad.
module bayer_bin_demosaic #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  localparam int AW = $clog2(H_ACTIVE * V_ACTIVE / 4)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_vsync,
  input  logic          i_href,
  input  logic          i_dv,
  input  logic [7:0]    i_pixel,
  output logic          o_dv,
  output logic [11:0]   o_rgb,
  output logic [AW-1:0] o_addr,
  output logic          o_frame_done
);

  // Counters carry one extra value so they can sit at H_ACTIVE / V_ACTIVE
  // and reject overlong lines and excess rows.
  localparam int XW   = $clog2(H_ACTIVE + 1);
  localparam int YW   = $clog2(V_ACTIVE + 1);
  localparam int LW   = (H_ACTIVE / 2 > 1) ? $clog2(H_ACTIVE / 2) : 1;
  localparam int LAST = H_ACTIVE * V_ACTIVE / 4 - 1;

  logic          synced;
  logic          href_p0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] row_base;
  logic [7:0]    held_p0;
  logic [15:0]   lb [H_ACTIVE/2];
  logic [15:0]   lb_rd_p1;

  logic          accept;
  logic          href_fall;
  logic [LW-1:0] xh;
  logic [AW-1:0] addr;

  // Green average truncates; only the top nibble of the 8-bit mean survives.
  function automatic logic [3:0] avg_g_nib(input logic [7:0] g1, input logic [7:0] g2);
    logic [8:0] sum;
    logic [7:0] mean;
    sum  = {1'b0, g1} + {1'b0, g2};
    mean = sum[8:1];
    return mean[7:4];
  endfunction

  function automatic logic [11:0] pack_rgb(input logic [7:0] r, input logic [7:0] g1,
                                           input logic [7:0] g2, input logic [7:0] b);
    return {r[7:4], avg_g_nib(g1, g2), b[7:4]};
  endfunction

  assign accept    = synced && i_dv && i_href && !i_vsync &&
                     (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
  assign href_fall = href_p0 && !i_href;
  assign xh        = x[LW:1];
  assign addr      = row_base + AW'(xh);

  // Sync tracking, position counters, byte holding and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      synced       <= 1'b0;
      href_p0      <= 1'b0;
      x            <= '0;
      y            <= '0;
      row_base     <= '0;
      held_p0      <= '0;
      o_dv         <= 1'b0;
      o_rgb        <= '0;
      o_addr       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      href_p0      <= i_href;
      o_dv         <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_vsync) begin
        synced   <= 1'b1;
        x        <= '0;
        y        <= '0;
        row_base <= '0;
        held_p0  <= '0;
      end else if (synced) begin
        if (href_fall) begin
          x <= '0;
          if (y < YW'(V_ACTIVE)) begin
            y <= y + 1'b1;
            // Advance by a full output row only when a row pair closes, so a
            // short line never drags later addresses with it.
            if (y[0]) row_base <= row_base + AW'(H_ACTIVE / 2);
          end
        end else if (accept) begin
          x <= x + 1'b1;
          if (!x[0]) begin
            held_p0 <= i_pixel;
          end else if (y[0]) begin
            o_dv         <= 1'b1;
            o_rgb        <= pack_rgb(i_pixel, lb_rd_p1[7:0], held_p0, lb_rd_p1[15:8]);
            o_addr       <= addr;
            o_frame_done <= (addr == AW'(LAST));
          end
        end
      end
    end
  end

  // Line buffer: even-row {B,G1} write, odd-row read one byte ahead of R.
  always_ff @(posedge clk) begin
    if (accept && !y[0] && x[0]) lb[xh] <= {held_p0, i_pixel};
    if (accept && y[0] && !x[0]) lb_rd_p1 <= lb[xh];
  end

endmodule

// File: tb/tb_bayer_bin_demosaic.sv
// Bench for bayer_bin_demosaic at 4x4: a behavioural model of the binning
// pushes expected pixels into a scoreboard as bytes are driven; a monitor
// pops and compares them as the DUT emits o_dv.
module tb_bayer_bin_demosaic;

  typedef logic [7:0] row_t [8];
  typedef struct {
    logic [11:0] rgb;
    logic [1:0]  addr;
    logic        fd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_vsync, i_href, i_dv;
  logic [7:0]  i_pixel;
  logic        o_dv;
  logic [11:0] o_rgb;
  logic [1:0]  o_addr;
  logic        o_frame_done;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];

  // bench model state
  bit         m_sync;
  int         m_x, m_y, m_base;
  logic [7:0] hb, hg;
  logic [7:0] mb [2];
  logic [7:0] mg [2];

  bayer_bin_demosaic #(.H_ACTIVE(4), .V_ACTIVE(4)) dut (
    .clk(clk), .reset(reset), .i_vsync(i_vsync), .i_href(i_href), .i_dv(i_dv),
    .i_pixel(i_pixel), .o_dv(o_dv), .o_rgb(o_rgb), .o_addr(o_addr),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (o_dv) begin
      if (sb.size() == 0) chk("unexp_dv", 32'(o_dv), 0);
      else begin
        e = sb.pop_front();
        chk("rgb", 32'(o_rgb), 32'(e.rgb));
        chk("addr", 32'(o_addr), 32'(e.addr));
        chk("frame_done", 32'(o_frame_done), 32'(e.fd));
        chk("latency", cyc, e.cyc);
      end
    end else if (o_frame_done) begin
      chk("fd_without_dv", 32'(o_frame_done), 0);
    end
  end

  task automatic model_clear(input bit sync);
    m_sync = sync; m_x = 0; m_y = 0; m_base = 0; hb = '0; hg = '0;
  endtask

  task automatic put_px(input logic [7:0] b);
    logic [8:0] gs;
    exp_t e;
    if (m_sync && m_x < 4 && m_y < 4) begin
      if (m_y % 2 == 0) begin
        if (m_x % 2 == 0) hb = b;
        else begin mb[m_x/2] = hb; mg[m_x/2] = b; end
      end else if (m_x % 2 == 0) begin
        hg = b;
      end else begin
        gs     = {1'b0, mg[m_x/2]} + {1'b0, hg};
        e.rgb  = {b[7:4], gs[8:5], mb[m_x/2][7:4]};
        e.addr = 2'(m_base + m_x/2);
        e.fd   = (m_base + m_x/2) == 3;
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
      m_x++;
    end
    i_pixel = b; i_dv = 1'b1;
    @(posedge clk); #2;
    i_dv = 1'b0;
  endtask

  task automatic end_line();
    i_href = 1'b0;
    @(posedge clk); #2;
    if (m_sync && m_y < 4) begin
      if (m_y % 2 == 1) m_base += 2;
      m_y++;
    end
    m_x = 0;
    @(posedge clk); #2;
  endtask

  task automatic line(input row_t b, input int n);
    i_href = 1'b1;
    for (int i = 0; i < n; i++) put_px(b[i]);
    end_line();
  endtask

  task automatic frame(input row_t r0, input row_t r1, input row_t r2, input row_t r3);
    line(r0, 4); line(r1, 4); line(r2, 4); line(r3, 4);
  endtask

  task automatic do_vsync(input bit with_dv);
    i_vsync = 1'b1;
    if (with_dv) begin i_dv = 1'b1; i_pixel = 8'hF0; end
    @(posedge clk); #2;
    i_dv = 1'b0;
    @(posedge clk); #2;
    i_vsync = 1'b0;
    model_clear(1);
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3;
    a0 = '{8'hA0, 8'h60, 8'hA0, 8'h60, 8'h11, 8'h22, 8'h00, 8'h00};
    a1 = '{8'h40, 8'hF0, 8'h40, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
    a2 = '{8'h12, 8'h0F, 8'h34, 8'h8E, 8'h00, 8'h00, 8'h00, 8'h00};
    a3 = '{8'h10, 8'hC7, 8'h70, 8'h59, 8'h00, 8'h00, 8'h00, 8'h00};
    b0 = '{8'h21, 8'h43, 8'h65, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00};
    b1 = '{8'h9A, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    b2 = '{8'hDE, 8'hF1, 8'h13, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00};
    b3 = '{8'h57, 8'h79, 8'h9B, 8'hBD, 8'h00, 8'h00, 8'h00, 8'h00};
    c0 = '{default: 8'h00}; c1 = '{default: 8'h00};
    c2 = '{default: 8'h00}; c3 = '{default: 8'h00};
    for (int i = 0; i < 4; i++) begin
      c0[i] = 8'($urandom); c1[i] = 8'($urandom);
      c2[i] = 8'($urandom); c3[i] = 8'($urandom);
    end

    reset = 1'b1; i_vsync = 1'b0; i_href = 1'b0; i_dv = 1'b0; i_pixel = '0;
    model_clear(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dv", 32'(o_dv), 0);
    chk("rst_rgb", 32'(o_rgb), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_fd", 32'(o_frame_done), 0);
    #1 reset = 1'b0;
    @(posedge clk); #2;

    // pixels before any vsync are ignored
    frame(a0, a1, a2, a3);

    // frame A: 6-byte first line, F5A quads, truncating green average
    do_vsync(0);
    line(a0, 6);
    line(a1, 4);
    chk("a_q1_rgb_lit", 32'(o_rgb), 32'h0F5A);
    chk("a_q1_addr_lit", 32'(o_addr), 1);
    line(a2, 4);
    line(a3, 4);
    chk("a_last_rgb_lit", 32'(o_rgb), 32'h0573);

    // frame B: short odd row does not shift the next row pair
    do_vsync(0);
    line(b0, 4);
    line(b1, 2);
    chk("b_q0_rgb_lit", 32'(o_rgb), 32'h0B62);
    chk("b_q0_addr_lit", 32'(o_addr), 0);
    line(b2, 4);
    line(b3, 4);
    chk("b_last_addr_lit", 32'(o_addr), 3);

    // vsync in the middle of row 1 aborts the frame, next frame restarts at 0
    do_vsync(0);
    line(a0, 4);
    i_href = 1'b1;
    put_px(8'h40); put_px(8'hF0);
    do_vsync(1);
    put_px(8'h40); put_px(8'hF0);
    end_line();
    do_vsync(0);
    frame(c0, c1, c2, c3);

    // async reset between G2 and R: outputs clear at once, silent until vsync
    do_vsync(0);
    line(a0, 4);
    i_href = 1'b1;
    put_px(8'h40);
    reset = 1'b1;
    model_clear(0);
    #1;
    chk("mid_rst_dv", 32'(o_dv), 0);
    chk("mid_rst_rgb", 32'(o_rgb), 0);
    chk("mid_rst_addr", 32'(o_addr), 0);
    chk("mid_rst_fd", 32'(o_frame_done), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    put_px(8'hF0);
    end_line();
    frame(b0, b1, b2, b3);
    do_vsync(0);
    frame(a0, a1, a2, a3);
    chk("post_rst_rgb_lit", 32'(o_rgb), 32'h0573);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
